// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// No logic; no latency; no flow control.
// Backpressure: not applicable.
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational D-bit add/subtract slice with ripple chain (carry or borrow).
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int D = 4
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         cin,
    input  logic         mode,
    output logic [D-1:0] s,
    output logic         cout
);

    logic [D:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < D; i++) begin
            s[i] = a[i] ^ b[i] ^ c[i];
            // Subtract chain propagates borrow: same formula with a inverted.
            if (mode == MODE_ADD) begin
                c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
            end else begin
                c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
            end
        end
    end

    assign cout = c[D];

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle N-bit add/subtract, D bits per clock, start/busy/done handshake.
// Latency: K = N/D cycles from accept to done; one operation per K cycles.
// Backpressure: start is ignored while busy; no output stall, results are held.
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    generate
        if ((N % D) != 0) begin : g_bad_ratio
            $error("digit_serial_addsub: N must be a multiple of D");
        end
    endgenerate

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_sh, b_sh, res_sh, res_next;
    logic           chain_q, mode_q, a_msb, b_msb;
    logic [D-1:0]   dig_s;
    logic           dig_c;
    logic           accept, last;

    addsub_digit #(.D(D)) u_digit (
        .a    (a_sh[D-1:0]),
        .b    (b_sh[D-1:0]),
        .cin  (chain_q),
        .mode (mode_q),
        .s    (dig_s),
        .cout (dig_c)
    );

    // Digits enter from the MSB side so after K shifts the result is aligned.
    generate
        if (K > 1) begin : g_multi
            assign res_next = {dig_s, res_sh[N-1:D]};
        end else begin : g_single
            assign res_next = dig_s;
        end
    endgenerate

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (cnt_q == CW'(K - 1));
    assign busy   = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            chain_q <= 1'b0;
            mode_q  <= MODE_ADD;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            done    <= 1'b0;
            y       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh    <= a;
                b_sh    <= b;
                mode_q  <= mode;
                chain_q <= cin;
                a_msb   <= a[N-1];
                b_msb   <= b[N-1];
                cnt_q   <= '0;
            end else if (state_q == RUN) begin
                a_sh    <= a_sh >> D;
                b_sh    <= b_sh >> D;
                res_sh  <= res_next;
                chain_q <= dig_c;
                cnt_q   <= cnt_q + 1'b1;
                if (last) begin
                    y    <= res_next;
                    cout <= dig_c;
                    zero <= (res_next == '0);
                    // Sign bits were captured at accept; the shifters have lost them.
                    if (mode_q == MODE_ADD) begin
                        ovf <= (a_msb == b_msb) && (dig_s[D-1] != a_msb);
                    end else begin
                        ovf <= (a_msb != b_msb) && (dig_s[D-1] != a_msb);
                    end
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: an N=16/D=4 instance and an N=16/D=16 instance
// checked against an arithmetic reference model plus directed literal vectors.
module tb_digit_serial_addsub;

    typedef struct packed {
        logic [15:0] y;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic        mode = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;

    logic [1:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
    logic [15:0] y_v [2];

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int kk [2] = '{4, 1};

    always #5 clk = ~clk;

    digit_serial_addsub #(.N(16), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .y(y_v[0]), .cout(cout_v[0]),
        .ovf(ovf_v[0]), .zero(zero_v[0])
    );

    digit_serial_addsub #(.N(16), .D(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .y(y_v[1]), .cout(cout_v[1]),
        .ovf(ovf_v[1]), .zero(zero_v[1])
    );

    function automatic res_t ref_op(logic m, logic [15:0] x, logic [15:0] z, logic c);
        res_t        r;
        logic [16:0] full;
        if (m == 1'b0) full = {1'b0, x} + {1'b0, z} + {16'b0, c};
        else           full = {1'b0, x} - {1'b0, z} - {16'b0, c};
        r.y    = full[15:0];
        r.cout = full[16];
        r.zero = (full[15:0] == 16'h0000);
        if (m == 1'b0) r.ovf = (x[15] == z[15]) && (full[15] != x[15]);
        else           r.ovf = (x[15] != z[15]) && (full[15] != x[15]);
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: actual %h required %h", name, idx, $time, act, exp);
        end
    endtask

    // Reference model: remaining-cycle countdown per instance, result from plain arithmetic.
    int   m_cnt  [2] = '{0, 0};
    res_t m_out  [2] = '{default: '0};
    res_t m_pend [2] = '{default: '0};
    logic m_done [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i]  <= 0;
                m_out[i]  <= '0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (m_cnt[i] == 0) begin
                    if (start_v[i]) begin
                        m_pend[i] <= ref_op(mode, a, b, cin);
                        m_cnt[i]  <= kk[i];
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    if (m_cnt[i] == 1) begin
                        m_out[i]  <= m_pend[i];
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 32'(busy_v[i]), 32'(m_cnt[i] != 0));
                chk("done", i, 32'(done_v[i]), 32'(m_done[i]));
                chk("y",    i, 32'(y_v[i]),    32'(m_out[i].y));
                chk("cout", i, 32'(cout_v[i]), 32'(m_out[i].cout));
                chk("ovf",  i, 32'(ovf_v[i]),  32'(m_out[i].ovf));
                chk("zero", i, 32'(zero_v[i]), 32'(m_out[i].zero));
            end
        end
    end

    task automatic launch(int idx, logic m, logic [15:0] x, logic [15:0] z, logic c);
        @(negedge clk);
        mode = m;
        a    = x;
        b    = z;
        cin  = c;
        start_v[idx] = 1'b1;
    endtask

    // Returns negedges from launch to the one where done is seen, and busy count.
    task automatic wait_done(int idx, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start_v[idx] = 1'b0;
            if (busy_v[idx]) bc++;
            if (done_v[idx]) break;
        end
        if (!done_v[idx]) begin
            checks++;
            errors++;
            $display("FAIL done_timeout[%0d]: actual no done required done within 40 cycles", idx);
        end
    endtask

    task automatic run_op(int idx, logic m, logic [15:0] x, logic [15:0] z, logic c,
                          logic [15:0] ey, logic ecout, logic eovf, logic ezero);
        int lat, bc;
        launch(idx, m, x, z, c);
        wait_done(idx, lat, bc);
        chk("latency",     idx, 32'(lat - 1), 32'(kk[idx]));
        chk("busy_cycles", idx, 32'(bc),      32'(kk[idx]));
        chk("lit_y",       idx, 32'(y_v[idx]),    32'(ey));
        chk("lit_cout",    idx, 32'(cout_v[idx]), 32'(ecout));
        chk("lit_ovf",     idx, 32'(ovf_v[idx]),  32'(eovf));
        chk("lit_zero",    idx, 32'(zero_v[idx]), 32'(ezero));
        @(negedge clk);
        chk("done_pulse",  idx, 32'(done_v[idx]), 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy_v[i]), 32'd0);
            chk("rst_done", i, 32'(done_v[i]), 32'd0);
            chk("rst_y",    i, 32'(y_v[i]),    32'd0);
            chk("rst_flags", i, {29'd0, cout_v[i], ovf_v[i], zero_v[i]}, 32'd0);
        end
        rst = 1'b0;
        cmp_en = 1'b1;

        run_op(0, 1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op(0, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(0, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op(0, 1'b1, 16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(0, 1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);

        // start held high through RUN with different operands must be ignored
        launch(0, 1'b1, 16'h0005, 16'h0003, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; mode = 1'b0; cin = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("held_done", 0, 32'(done_v[0]), 32'd1);
        chk("held_y",    0, 32'(y_v[0]),    32'h0002);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("held_not_accepted", 0, 32'(busy_v[0]), 32'd0);

        // start in the done cycle is accepted
        launch(0, 1'b0, 16'h0100, 16'h0023, 1'b0);
        wait_done(0, lat, bc);
        chk("b2b_first_y", 0, 32'(y_v[0]), 32'h0123);
        mode = 1'b1; a = 16'h0010; b = 16'h0001; cin = 1'b0;
        start_v[0] = 1'b1;
        wait_done(0, lat, bc);
        chk("b2b_latency", 0, 32'(lat - 1), 32'd4);
        chk("b2b_second_y", 0, 32'(y_v[0]), 32'h000F);

        // reset in the second RUN cycle aborts without done
        launch(0, 1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("abort_y",    0, 32'(y_v[0]),    32'd0);
        chk("abort_done", 0, 32'(done_v[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        chk("abort_no_done", 0, 32'(ndone), 32'd0);

        run_op(1, 1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op(1, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op(1, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised multi-cycle adder/subtractor that processes `D` bits per clock over `N`-bit operands, with a start/busy/done handshake. It succeeds the combinational ripple subtractor. It adds an add/subtract mode, carry/borrow chaining across digits, and signed-overflow and zero flags. Wide datapaths use it when a full-width combinational ripple chain would not meet timing.

## Interface
- `N`, default 16: operand/result width in bits.
- `D`, default 4: digit width, i.e. bits processed per cycle. `N % D == 0` is required, and a non-integer ratio is an elaboration error. `K = N/D` is the number of cycles per operation.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request; sampled only in IDLE.
- `mode` input, 1 bit: 0 = add (`a+b+cin`), 1 = subtract (`a-b-cin`).
- `a` input, `N` bits: operand A, latched on accept.
- `b` input, `N` bits: operand B, latched on accept.
- `cin` input, 1 bit: carry-in (add) or borrow-in (sub), latched on accept.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse marking new results.
- `y` output, `N` bits: result, held between completions.
- `cout` output, 1 bit: carry-out (add) or borrow-out (sub, 1 when `a < b+cin` unsigned).
- `ovf` output, 1 bit: two's-complement overflow.
- `zero` output, 1 bit: `y == 0`.

## Operation
- **States.**
  - IDLE → RUN on `start` (accept).
  - RUN → IDLE after digit `K-1` is processed.
  - There is no other state.
- **On accept:**
  - latch `a`, `b`, `mode` and `cin` into shift registers and the chain flop;
  - clear the digit counter.
- **Each RUN cycle:**
  - combine the low `D` bits of A and B with the chain bit;
  - shift the digit result into the internal result register from the MSB side;
  - update the chain bit;
  - increment the counter.
- **Digit equations, per bit `i`:**
  - `s = a^b^c`;
  - add: `c' = a&b | (a^b)&c`;
  - sub: `c' = ~a&b | ~(a^b)&c`.
- **Completion (last digit):**
  - `y` gets the full result;
  - `cout` gets the final chain bit;
  - `zero` gets `(result==0)`;
  - `ovf`, add: `a[N-1]==b[N-1] && y[N-1]!=a[N-1]`;
  - `ovf`, sub: `a[N-1]!=b[N-1] && y[N-1]!=a[N-1]`, where `a`, `b` are the latched operands;
  - `done` is pulsed.
- **Boundary conditions:**
  - `start` while busy is ignored entirely and does not disturb the operation in flight.
  - `start` in the `done` cycle is accepted, since the block is already in IDLE.
  - `K == 1` (`D == N`) completes in one cycle.
  - All arithmetic is modulo 2^N.
- **Reset, async, at any time including mid-operation:**
  - state returns to IDLE;
  - `busy`, `done`, `y`, `cout`, `ovf` and `zero` all go to 0;
  - the partial result is discarded and no `done` is produced for the aborted operation.

## Timing
- Accept edge E0; digits are processed at edges E1..EK.
- `busy` is high from E0 until EK, exactly `K` cycles.
- `done`, `y`, `cout`, `ovf` and `zero` update at EK. `done` deasserts at E(K+1) unless another completion occurs.
- Start-to-done latency is `K` cycles; sustained throughput is one operation per `K` cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- Critical path is one `D`-bit ripple chain plus the chain flop.

## Structure
- `addsub_pkg` holds:
  - the state enum (IDLE, RUN);
  - the mode constants `MODE_ADD = 1'b0` and `MODE_SUB = 1'b1`.
- Sub-module `addsub_digit #(D)` is a combinational `D`-bit add/sub slice:
  - inputs: `a`, `b`, chain in, `mode`;
  - outputs: `s`, chain out.
- The top module holds the FSM, counter, shift registers and output registers.

## Test plan
Configuration `N=16`, `D=4`, `K=4` unless noted.
- **Reset values:** assert `rst` → all outputs 0, `busy` = 0.
- **Basic subtract:** sub `0x0005 - 0x0003`, `cin`=0 → `busy` high 4 cycles; `done` pulses once; `y=0x0002`, `cout=0`, `ovf=0`, `zero=0`.
- **Borrow and overflow:**
  - sub `0x0000 - 0x0001` → `y=0xFFFF`, `cout=1`, `ovf=0`;
  - sub `0x8000 - 0x0001` → `y=0x7FFF`, `cout=0`, `ovf=1`;
  - sub `0x0003 - 0x0003`, `cin`=1 → `y=0xFFFF`, `cout=1`.
- **Add corners:**
  - `0x7FFF + 0x0001` → `y=0x8000`, `ovf=1`, `cout=0`;
  - `0xFFFF + 0x0001` → `y=0x0000`, `cout=1`, `zero=1`, `ovf=0`.
- **Handshake:**
  - `start` held during RUN with different operands → ignored, and the first result is unchanged;
  - `start` in the `done` cycle → accepted, and the second `done` arrives exactly 4 cycles later.
- **Reset and single-cycle configuration:**
  - `rst` asserted in the 2nd RUN cycle → `busy` = 0 immediately, `y=0`, and no `done`;
  - repeat the basic subtract with `D=16` → `done` 1 cycle after accept.
